// File: rtl/load_store_unit_if.sv
// Request, response and data-memory port bundle for load_store_unit.
// Request/response handshake: a transfer occurs on a rising edge where valid and ready are
// both 1; the valid side holds its payload stable until that edge, and ready never depends on valid.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_control;
    logic        mem_write_control;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read_control, mem_write_control, mem_addr, mem_wdata, dbg_state
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read_control, mem_write_control, mem_addr, mem_wdata, dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: RISC-V byte/half/word accesses onto a word-only memory, sub-word stores via RMW.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic        funct3_legal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    logic        req_ready;
    logic        rsp_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    // Request classification, evaluated on the incoming request while IDLE.
    always_comb begin
        if (bus.req_write) begin
            funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                           (bus.req_funct3 == 3'b010);
        end else begin
            funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                           (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                           (bus.req_funct3 == 3'b101);
        end
        out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        req_err = !funct3_legal || out_of_range || misaligned;
    end

    // Lane extraction for loads and lane merge for sub-word stores; addr[0] is ignored for halves.
    always_comb begin
        byte_shift = {addr_q[1:0], 3'b000};
        half_shift = {addr_q[1], 4'b0000};
        lane_byte  = 8'(bus.mem_rdata >> byte_shift);
        lane_half  = 16'(bus.mem_rdata >> half_shift);
        case (funct3_q)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_value = {24'b0, lane_byte};
            3'b101:  load_value = {16'b0, lane_half};
            default: load_value = bus.mem_rdata;
        endcase
        merged_word = bus.mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged_word[byte_shift +: 8] = wdata_q[7:0];
        end else begin
            merged_word[half_shift +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        funct3_d  = funct3_q;
        write_d   = write_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 32'b0;
        case (state_q)
            IDLE: begin
                // Gated so that req_ready reads 0 while reset is held.
                req_ready = reset_n;
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    funct3_d = bus.req_funct3;
                    write_d  = bus.req_write;
                    rdata_d  = 32'b0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_write && (bus.req_funct3[1:0] != 2'b10)) begin
                        state_d = RMW_RD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    mem_wr    = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_rd  = 1'b1;
                    rdata_d = load_value;
                end
                state_d = RESP;
            end
            RMW_RD: begin
                mem_rd  = 1'b1;
                wdata_d = merged_word;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_wr    = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            rdata_q  <= 32'b0;
            funct3_q <= 3'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready         = req_ready;
    assign bus.rsp_valid         = rsp_valid;
    assign bus.rsp_rdata         = rsp_valid ? rdata_q : 32'b0;
    assign bus.rsp_err           = rsp_valid & err_q;
    assign bus.mem_read_control  = mem_rd;
    assign bus.mem_write_control = mem_wr;
    assign bus.mem_addr          = (mem_rd || mem_wr) ? {addr_q[31:2], 2'b00} : 32'b0;
    assign bus.mem_wdata         = mem_wdata;
    assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference memory, directed cases, random traffic.
module tb_load_store_unit;
    localparam int MEM_WORDS = 256;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Data memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_write_control) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    logic [7:0]  ref_b [0:4*MEM_WORDS-1];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: memory as bytes; an access touches size bytes at the naturally aligned base.
    function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err,
                                  output int lat, output int nrd, output int nwr);
        logic        legal;
        logic        mis;
        int          size;
        int          sh;
        logic [31:0] base;
        logic [31:0] v;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (addr % size) != 0;
`endif
        err = !legal || (addr >= 32'(4 * MEM_WORDS)) || mis;
        rd  = 32'b0;
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
            return;
        end
        base = addr - (addr % size);
        if (wr) begin
            for (int i = 0; i < size; i++) ref_b[base + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
        end else begin
            v = 32'b0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[base + i];
            sh = 32 - 8 * size;
            v  = v << sh;
            if (f3[2]) v = v >> sh;
            else       v = $signed(v) >>> sh;
            rd = v;
            lat = 2; nrd = 1; nwr = 0;
        end
    endfunction

    // Compare process: memory-port invariants every cycle, response against the model whenever valid.
    always @(negedge clk) begin
        chk("strobe_excl", {31'b0, bus.mem_read_control & bus.mem_write_control}, 32'd0);
        if (!bus.mem_read_control && !bus.mem_write_control) begin
            chk("mem_addr_idle", bus.mem_addr, 32'd0);
            chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
        end else begin
            chk("mem_addr_align", {30'b0, bus.mem_addr[1:0]}, 32'd0);
        end
        if (bus.mem_read_control) rd_cnt++;
        if (bus.mem_write_control) wr_cnt++;
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 32'd1, 32'd0);
            end else begin
                chk("rsp_rdata", bus.rsp_rdata, exp_q[0]);
                chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err_q[0]});
            end
        end
    end

    task automatic preload(input int w, input logic [31:0] val);
        pl_en   = 1'b1;
        pl_addr = w[7:0];
        pl_data = val;
        for (int i = 0; i < 4; i++) ref_b[4*w + i] = val[8*i +: 8];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
        chk({name, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({name, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({name, "_rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
        chk({name, "_mem_rd"}, {31'b0, bus.mem_read_control}, 32'd0);
        chk({name, "_mem_wr"}, {31'b0, bus.mem_write_control}, 32'd0);
        chk({name, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // Driver: one request, called and returning on a falling edge with the unit idle.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, input string name,
                          output logic [31:0] got_rd, output logic got_err, output int got_lat);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, e_nrd, e_nwr, rd0, wr0;
        model(wr, f3, addr, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
        chk({name, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        exp_q.push_back(e_rd);
        exp_err_q.push_back(e_err);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        got_lat = 1;
        while (!bus.rsp_valid && got_lat < 8) begin
            @(negedge clk);
            got_lat++;
        end
        chk({name, "_latency"}, 32'(got_lat), 32'(e_lat));
        got_rd  = bus.rsp_rdata;
        got_err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
            chk({name, "_hold_rdata"}, bus.rsp_rdata, got_rd);
            chk({name, "_hold_err"}, {31'b0, bus.rsp_err}, {31'b0, got_err});
            chk({name, "_hold_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
        end
        chk({name, "_rsp_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({name, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
        chk({name, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(e_nrd));
        chk({name, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(e_nwr));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        int          sel;

        reset_n        = 1'b0;
        pl_en          = 1'b0;
        pl_addr        = 8'd0;
        pl_data        = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int w = 0; w < MEM_WORDS; w++) preload(w, $urandom);

        // Reset while the write half of an SB read-modify-write is pending.
        preload(4, 32'h5566_7788);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h0000_00AA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid_rd_phase", {31'b0, bus.mem_read_control}, 32'd1);
        @(negedge clk);
        chk("rst_mid_wr_phase", {31'b0, bus.mem_write_control}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_word", mem[4], 32'h5566_7788);

        do_req(1'b1, 3'b010, 32'h20, 32'h8000_00F1, 0, "sw20", rd, er, lat);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20", rd, er, lat);
        chk("lw20_lit_rdata", rd, 32'h8000_00F1);
        chk("lw20_lit_err", {31'b0, er}, 32'd0);
        chk("lw20_lit_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 0, "lb20", rd, er, lat);
        chk("lb20_lit", rd, 32'hFFFF_FFF1);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, 0, "lbu20", rd, er, lat);
        chk("lbu20_lit", rd, 32'h0000_00F1);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 0, "lh22", rd, er, lat);
        chk("lh22_lit", rd, 32'hFFFF_8000);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 0, "lhu22", rd, er, lat);
        chk("lhu22_lit", rd, 32'h0000_8000);

        preload(12, 32'h1122_3344);
        do_req(1'b1, 3'b000, 32'h31, 32'h0000_00AB, 0, "sb31", rd, er, lat);
        chk("sb31_lit_lat", 32'(lat), 32'd3);
        do_req(1'b1, 3'b001, 32'h32, 32'h0000_CDEF, 0, "sh32", rd, er, lat);
        chk("rmw_word30_lit", mem[12], 32'hCDEF_AB44);

        do_req(1'b0, 3'b010, 32'h400, 32'h0, 0, "lw400", rd, er, lat);
        chk("lw400_lit_err", {31'b0, er}, 32'd1);
        chk("lw400_lit_lat", 32'(lat), 32'd1);
        do_req(1'b0, 3'b011, 32'h20, 32'h0, 0, "illegal_ld", rd, er, lat);
        chk("illegal_ld_lit_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 3'b001, 32'h21, 32'h0, 0, "lh21", rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh21_lit_err", {31'b0, er}, 32'd1);
        chk("lh21_lit_rdata", rd, 32'h0);
`else
        chk("lh21_lit_err", {31'b0, er}, 32'd0);
        chk("lh21_lit_rdata", rd, 32'h0000_00F1);
`endif

        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5, "hold5", rd, er, lat);
        chk("hold5_lit", rd, 32'h8000_00F1);

        for (int n = 0; n < 300; n++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                case (sel)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            sel = $urandom_range(0, 19);
            if (sel == 0) addr = $urandom;
            else if (sel == 1) addr = 32'($urandom_range(1020, 1100));
            else addr = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
            do_req(wr, f3, addr, $urandom, $urandom_range(0, 3), "rand", rd, er, lat);
        end

        for (int w = 0; w < MEM_WORDS; w++) begin
            word = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
            chk("final_mem", mem[w], word);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
